// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// Module   : bp_types (package)
// Brief    : Shared types for the branch predictor: counter type, counter
//            state encodings and the BTB entry layout.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bp_types;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Tag field is sized for the narrowest legal index placement (index
    // starting at bit 2); unused upper tag bits stay zero.
    localparam int c_TAG_W = 30;

    typedef struct packed {
        logic               valid;
        logic               uncond;
        logic [c_TAG_W-1:0] tag;
        logic [31:2]        target;
    } btb_entry_t;

endpackage

`default_nettype wire

// File: rtl/branch_predictor_sat_ctr.sv
// ============================================================================
// Module   : bp_sat_ctr
// Brief    : Two-bit saturating increment/decrement, used for each counter
//            table write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_sat_ctr
    import bp_types::*;
(
    input  ctr_t ctr_in,
    input  logic inc,
    output ctr_t ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (inc) begin
            if (ctr_in != ST) ctr_out = ctr_in + 2'd1;
        end else begin
            if (ctr_in != SNT) ctr_out = ctr_in - 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Brief    : Fetch-stage predictor: direct-mapped tagged BTB plus 2-bit
//            direction counters, bimodal or gshare indexed, with perf counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predictor
    import bp_types::*;
#(
    parameter int   IDX_BITS  = 6,
    parameter int   IDX_START = 2,
    parameter int   GHR_BITS  = 0,
    parameter ctr_t CTR_INIT  = 2'b01,
    localparam int  c_GHR_W   = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [31:0]        pc_if,
    output logic               pred_hit,
    output logic               pred_taken,
    output logic [31:0]        pred_target,
    output logic [c_GHR_W-1:0] pred_ghr,
    input  logic               upd_valid,
    input  logic               upd_uncond,
    input  logic [31:0]        upd_pc,
    input  logic [c_GHR_W-1:0] upd_ghr,
    input  logic               upd_taken,
    input  logic [31:0]        upd_target,
    input  logic               upd_mispredict,
    output logic [31:0]        n_branches,
    output logic [31:0]        n_mispredicts
);

    localparam int c_ENTRIES = 1 << IDX_BITS;
    localparam int c_TAG_LSB = IDX_START + IDX_BITS;

    function automatic logic [c_TAG_W-1:0] tag_of(input logic [31:0] pc);
        return c_TAG_W'(pc >> c_TAG_LSB);
    endfunction

    btb_entry_t          r_btb [c_ENTRIES];
    ctr_t                r_ctr [c_ENTRIES];
    logic [c_GHR_W-1:0]  r_ghr;
    logic [31:0]         r_n_br;
    logic [31:0]         r_n_mis;

    logic [IDX_BITS-1:0] w_bi, w_ci, w_ubi, w_uci;
    logic [IDX_BITS-1:0] w_hist_if, w_hist_upd;
    logic [c_GHR_W-1:0]  w_ghr_next;
    logic                w_upd_en;
    ctr_t                w_ctr_next;
    btb_entry_t          w_entry;
    logic                w_unused_bits;

    assign w_bi  = pc_if[IDX_START +: IDX_BITS];
    assign w_ubi = upd_pc[IDX_START +: IDX_BITS];

    generate
        if (GHR_BITS > 0) begin : g_gshare
            assign w_hist_if  = IDX_BITS'(r_ghr);
            assign w_hist_upd = IDX_BITS'(upd_ghr);
        end else begin : g_bimodal
            assign w_hist_if  = '0;
            assign w_hist_upd = '0;
        end

        if (GHR_BITS > 1) begin : g_hist_shift
            assign w_ghr_next = {r_ghr[c_GHR_W-2:0], upd_taken};
        end else if (GHR_BITS == 1) begin : g_hist_one
            assign w_ghr_next = upd_taken;
        end else begin : g_hist_none
            assign w_ghr_next = '0;
        end
    endgenerate

    assign w_ci  = w_bi ^ w_hist_if;
    // Training index follows the history the instruction was predicted with.
    assign w_uci = w_ubi ^ w_hist_upd;

    assign w_upd_en = upd_valid & ~stall;

    bp_sat_ctr u_sat_ctr (
        .ctr_in  (r_ctr[w_uci]),
        .inc     (upd_taken),
        .ctr_out (w_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
                r_ctr[i]       <= CTR_INIT;
            end
            r_ghr   <= '0;
            r_n_br  <= '0;
            r_n_mis <= '0;
        end else if (w_upd_en) begin
            if (upd_taken) begin
                r_btb[w_ubi] <= '{valid:  1'b1,
                                  uncond: upd_uncond,
                                  tag:    tag_of(upd_pc),
                                  target: upd_target[31:2]};
            end
            if (!upd_uncond) begin
                r_ctr[w_uci] <= w_ctr_next;
                r_ghr        <= w_ghr_next;
            end
            r_n_br  <= r_n_br + 32'd1;
            r_n_mis <= r_n_mis + 32'(upd_mispredict);
        end
    end

    // Reads come straight from the arrays, so a same-cycle update is not visible.
    assign w_entry       = r_btb[w_bi];
    assign pred_hit      = w_entry.valid && (w_entry.tag == tag_of(pc_if));
    assign pred_taken    = pred_hit && (w_entry.uncond || r_ctr[w_ci][1]);
    assign pred_target   = {w_entry.target, 2'b00};
    assign pred_ghr      = r_ghr;
    assign n_branches    = r_n_br;
    assign n_mispredicts = r_n_mis;

    assign w_unused_bits = ^{pc_if[1:0], upd_pc[1:0], upd_target[1:0], upd_ghr};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Directed self-checking bench; one bimodal and one gshare instance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    logic        clk, rst, stall;
    int          n_tests, n_fail;

    // bimodal instance
    logic        pc_hit, pc_taken, upd_valid, upd_uncond, upd_taken, upd_mis;
    logic [31:0] pc_if, pc_target, upd_pc, upd_target, n_br, n_mis;
    logic [0:0]  b_ghr_out, b_ghr_in;

    // gshare instance
    logic        g_hit, g_taken, g_upd_valid, g_upd_uncond, g_upd_taken, g_upd_mis;
    logic [31:0] g_pc_if, g_target, g_upd_pc, g_upd_target, g_n_br, g_n_mis;
    logic [3:0]  g_ghr_out, g_ghr_in;

    branch_predictor #(.IDX_BITS(6), .IDX_START(2), .GHR_BITS(0), .CTR_INIT(2'b01)) dut_bi (
        .clk(clk), .rst(rst), .stall(stall), .pc_if(pc_if),
        .pred_hit(pc_hit), .pred_taken(pc_taken), .pred_target(pc_target), .pred_ghr(b_ghr_out),
        .upd_valid(upd_valid), .upd_uncond(upd_uncond), .upd_pc(upd_pc), .upd_ghr(b_ghr_in),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mis),
        .n_branches(n_br), .n_mispredicts(n_mis)
    );

    branch_predictor #(.IDX_BITS(6), .IDX_START(2), .GHR_BITS(4), .CTR_INIT(2'b01)) dut_gs (
        .clk(clk), .rst(rst), .stall(stall), .pc_if(g_pc_if),
        .pred_hit(g_hit), .pred_taken(g_taken), .pred_target(g_target), .pred_ghr(g_ghr_out),
        .upd_valid(g_upd_valid), .upd_uncond(g_upd_uncond), .upd_pc(g_upd_pc), .upd_ghr(g_ghr_in),
        .upd_taken(g_upd_taken), .upd_target(g_upd_target), .upd_mispredict(g_upd_mis),
        .n_branches(g_n_br), .n_mispredicts(g_n_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bupd(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic tk, input logic unc, input logic mis);
        upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_uncond = unc; upd_mis = mis;
        upd_valid = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic gupd(input logic [31:0] pc, input logic [3:0] gh,
                        input logic tk, input logic [31:0] tgt);
        g_upd_pc = pc; g_ghr_in = gh; g_upd_taken = tk; g_upd_target = tgt;
        g_upd_uncond = 1'b0; g_upd_mis = 1'b0;
        g_upd_valid = 1'b1;
        @(posedge clk); #1;
        g_upd_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        pc_if = pc; #1;
    endtask

    task automatic glook(input logic [31:0] pc);
        g_pc_if = pc; #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b0; stall = 1'b0;
        pc_if = 32'h100; upd_valid = 0; upd_uncond = 0; upd_taken = 0; upd_mis = 0;
        upd_pc = 0; upd_target = 0; b_ghr_in = '0;
        g_pc_if = 32'h100; g_upd_valid = 0; g_upd_uncond = 0; g_upd_taken = 0; g_upd_mis = 0;
        g_upd_pc = 0; g_upd_target = 0; g_ghr_in = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit",   32'(pc_hit), 32'd0);
        chk("rst_taken", 32'(pc_taken), 32'd0);
        chk("rst_nbr",   n_br, 32'd0);
        chk("rst_nmis",  n_mis, 32'd0);
        chk("rst_ghr",   32'(g_ghr_out), 32'd0);
        rst = 1'b1;

        // Bimodal training: ctr 01 -> 10 -> 11
        bupd(32'h100, 32'h140, 1, 0, 1);
        bupd(32'h100, 32'h140, 1, 0, 0);
        look(32'h100);
        chk("train_hit",    32'(pc_hit), 32'd1);
        chk("train_taken",  32'(pc_taken), 32'd1);
        chk("train_target", pc_target, 32'h140);
        chk("train_nbr",    n_br, 32'd2);
        chk("train_nmis",   n_mis, 32'd1);
        chk("bi_ghr",       32'(b_ghr_out), 32'd0);

        // Saturate at 3, then hysteresis
        repeat (4) bupd(32'h100, 32'h140, 1, 0, 0);
        bupd(32'h100, 32'h140, 0, 0, 0);
        look(32'h100);
        chk("hyst_taken", 32'(pc_taken), 32'd1);
        repeat (2) bupd(32'h100, 32'h140, 0, 0, 0);
        look(32'h100);
        chk("nt_taken", 32'(pc_taken), 32'd0);
        chk("nt_hit",   32'(pc_hit), 32'd1);
        // Saturate at 0: one extra NT then one T leaves ctr at 1
        bupd(32'h100, 32'h140, 0, 0, 0);
        bupd(32'h100, 32'h140, 1, 0, 0);
        look(32'h100);
        chk("sat0_taken", 32'(pc_taken), 32'd0);
        chk("sat_nbr",    n_br, 32'd11);

        // Jal at 0x200 (same index 0, different tag); counter stays 1
        bupd(32'h200, 32'h283, 1, 1, 0);
        look(32'h200);
        chk("jal_hit",    32'(pc_hit), 32'd1);
        chk("jal_taken",  32'(pc_taken), 32'd1);
        chk("jal_target", pc_target, 32'h280);
        look(32'h100);
        chk("jal_evict",  32'(pc_hit), 32'd0);
        bupd(32'h100, 32'h140, 1, 0, 0);   // ctr 1 -> 2
        bupd(32'h100, 32'h140, 0, 0, 0);   // ctr 2 -> 1
        look(32'h100);
        chk("jal_ctr_taken", 32'(pc_taken), 32'd0);
        chk("jal_ctr_hit",   32'(pc_hit), 32'd1);

        // Not-taken alias at 0x200 must not overwrite the entry
        bupd(32'h200, 32'h300, 0, 0, 0);   // ctr 1 -> 0
        look(32'h100);
        chk("alias_hit",    32'(pc_hit), 32'd1);
        chk("alias_target", pc_target, 32'h140);
        look(32'h200);
        chk("alias_miss",   32'(pc_hit), 32'd0);
        chk("alias_nbr",    n_br, 32'd15);

        // Stall holds a presented update
        pc_if = 32'h100;
        upd_pc = 32'h100; upd_target = 32'h140; upd_taken = 1; upd_uncond = 0; upd_mis = 1;
        upd_valid = 1'b1; stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_nbr",   n_br, 32'd15);
        chk("stall_nmis",  n_mis, 32'd1);
        chk("stall_taken", 32'(pc_taken), 32'd0);
        stall = 1'b0;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        chk("release_nbr",   n_br, 32'd16);
        chk("release_nmis",  n_mis, 32'd2);
        chk("release_taken", 32'(pc_taken), 32'd0);
        bupd(32'h100, 32'h140, 1, 0, 0);   // ctr 1 -> 2
        look(32'h100);
        chk("post_stall_taken", 32'(pc_taken), 32'd1);

        // Same-cycle lookup and update on one index returns old value
        upd_pc = 32'h100; upd_target = 32'h140; upd_taken = 0; upd_uncond = 0; upd_mis = 0;
        upd_valid = 1'b1;
        #1;
        chk("same_cyc_old", 32'(pc_taken), 32'd1);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        chk("same_cyc_new", 32'(pc_taken), 32'd0);
        chk("same_cyc_nbr", n_br, 32'd18);

        // Gshare: build history 1010 at pc 0x100 with snapshot 0 (ctr[0] ends at 1)
        gupd(32'h100, 4'h0, 1, 32'h180);
        gupd(32'h100, 4'h0, 0, 32'h180);
        gupd(32'h100, 4'h0, 1, 32'h180);
        gupd(32'h100, 4'h0, 0, 32'h180);
        glook(32'h100);
        chk("gs_ghr",     32'(g_ghr_out), 32'hA);
        chk("gs_hit",     32'(g_hit), 32'd1);
        chk("gs_target",  g_target, 32'h180);
        chk("gs_init",    32'(g_taken), 32'd0);
        gupd(32'h100, 4'hA, 1, 32'h180);   // ctr[0x0A] 1 -> 2, ghr 0101
        glook(32'h100);
        chk("gs_ghr5",    32'(g_ghr_out), 32'h5);
        chk("gs_other",   32'(g_taken), 32'd0);
        gupd(32'h40, 4'h0, 0, 32'h0);      // ghr back to 1010
        glook(32'h100);
        chk("gs_trained", 32'(g_taken), 32'd1);
        // Same-cycle at index 0x0A
        g_upd_pc = 32'h100; g_ghr_in = 4'hA; g_upd_taken = 0; g_upd_target = 32'h180;
        g_upd_valid = 1'b1;
        #1;
        chk("gs_same_old", 32'(g_taken), 32'd1);
        @(posedge clk); #1;
        g_upd_valid = 1'b0;
        chk("gs_same_ghr", 32'(g_ghr_out), 32'h4);
        chk("gs_same_new", 32'(g_taken), 32'd0);
        chk("gs_nbr",      g_n_br, 32'd7);

        // Reset mid-operation discards a concurrent update
        upd_pc = 32'h100; upd_target = 32'h140; upd_taken = 1; upd_uncond = 0; upd_mis = 1;
        upd_valid = 1'b1; rst = 1'b0;
        @(posedge clk); #1;
        upd_valid = 1'b0; rst = 1'b1;
        look(32'h100);
        chk("mid_rst_hit",  32'(pc_hit), 32'd0);
        chk("mid_rst_nbr",  n_br, 32'd0);
        chk("mid_rst_nmis", n_mis, 32'd0);
        glook(32'h100);
        chk("mid_rst_gghr", 32'(g_ghr_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
